// File: rtl/bus_arb_pkg.sv
// Shared definitions for the split-capable two-master bus arbiter.
//   arb_state_e     : arbiter FSM states (IDLE, GNT1, GNT2)
//   M1 / M2         : master ID constants used for owner, msel and tie history
//   DEF_SPLIT_TMO_W : default width of the split-timeout counter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT1 = 2'd1,
    ST_GNT2 = 2'd2
  } arb_state_e;

  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  localparam int DEF_SPLIT_TMO_W = 8;

endpackage

// File: rtl/split_tracker.sv
// Split record for the bus arbiter: remembers which master was parked by a
// split, latches a split_done that cannot be served yet, and times out a
// split that is never resumed.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   take            : arbiter accepted a split this cycle (only when not valid)
//   take_owner      : master that owned the bus when the split was accepted
//   split_done      : slave ready to resume (one-cycle pulse)
//   arb_idle        : arbiter FSM is in IDLE this cycle
//   rec_valid       : a split is outstanding
//   rec_owner       : master parked by the outstanding split
//   resume          : resume the parked master on the next edge (combinational)
//   msplit1/msplit2 : master parked flags
//   split_tmo       : one-cycle pulse when the split times out
module split_tracker
  import bus_arb_pkg::*;
#(
  parameter int SPLIT_TMO_W = DEF_SPLIT_TMO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic take,
  input  logic take_owner,
  input  logic split_done,
  input  logic arb_idle,
  output logic rec_valid,
  output logic rec_owner,
  output logic resume,
  output logic msplit1,
  output logic msplit2,
  output logic split_tmo
);

  localparam logic [SPLIT_TMO_W-1:0] CNT_MAX = '1;

  logic                   valid_q, valid_d;
  logic                   owner_q, owner_d;
  logic                   done_lat_q, done_lat_d;
  logic [SPLIT_TMO_W-1:0] cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;

  logic                   done_pend;
  logic [SPLIT_TMO_W-1:0] cnt_inc;
  logic                   expire;

  // A latched split_done counts as "resumed": the counter freezes and the
  // timeout can no longer fire, so done always wins over expiry.
  assign done_pend = valid_q & (split_done | done_lat_q);
  assign cnt_inc   = cnt_q + SPLIT_TMO_W'(1);
  assign expire    = valid_q & ~done_pend & (cnt_inc == CNT_MAX);
  assign resume    = done_pend & arb_idle;

  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    done_lat_d = done_lat_q;
    cnt_d      = cnt_q;
    tmo_d      = 1'b0;
    if (take) begin
      valid_d    = 1'b1;
      owner_d    = take_owner;
      done_lat_d = 1'b0;
      cnt_d      = '0;
    end else if (valid_q) begin
      if (resume) begin
        valid_d    = 1'b0;
        done_lat_d = 1'b0;
        cnt_d      = '0;
      end else if (done_pend) begin
        done_lat_d = 1'b1;
      end else if (expire) begin
        valid_d = 1'b0;
        cnt_d   = '0;
        tmo_d   = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      owner_q    <= M1;
      done_lat_q <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      owner_q    <= owner_d;
      done_lat_q <= done_lat_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign rec_valid = valid_q;
  assign rec_owner = owner_q;
  assign msplit1   = valid_q & (owner_q == M1);
  assign msplit2   = valid_q & (owner_q == M2);
  assign split_tmo = tmo_q;

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master bus arbiter with split-transaction support.
// Protocol: a master raises breqx and keeps it high for the whole tenure;
// bgrantx rises one edge after breqx is sampled in IDLE and falls one edge
// after breqx is sampled low (or a split is accepted). All outputs are
// registered.
// Optional feature macro: ARB_ROUND_ROBIN_EN -- when defined a simultaneous
// request goes to the master not granted most recently (M2 first after
// reset); when undefined M1 always wins a tie.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   breq1, breq2      : bus requests from masters 1 and 2
//   split, split_done : slave split pulse / slave ready-to-resume pulse
//   bgrant1, bgrant2  : bus grants
//   msel              : bus owner mux select (0 = M1, 1 = M2), holds in IDLE
//   msplit1, msplit2  : master parked by a split
//   split_tmo         : one-cycle pulse when a split times out
//   dbg_state         : current arbiter FSM state
module split_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int SPLIT_TMO_W = DEF_SPLIT_TMO_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       breq1,
  input  logic       breq2,
  input  logic       split,
  input  logic       split_done,
  output logic       bgrant1,
  output logic       bgrant2,
  output logic       msel,
  output logic       msplit1,
  output logic       msplit2,
  output logic       split_tmo,
  output arb_state_e dbg_state
);

  arb_state_e state_q, state_d;
  logic       msel_q, msel_d;
  // Low for the first edge after reset so no grant is issued on it.
  logic       arm_q;

  logic rec_valid, rec_owner, resume;
  logic ms1, ms2;
  logic req1_eff, req2_eff;
  logic split_take, take_owner;
  logic grant_start, grant_id;
  logic tie_pick;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign tie_pick = ~last_q;
`else
  assign tie_pick = M1;
`endif

  // A parked master's request is ignored until it is resumed or times out.
  assign req1_eff   = breq1 & ~ms1;
  assign req2_eff   = breq2 & ~ms2;
  assign split_take = split & ~rec_valid & (state_q != ST_IDLE);
  assign take_owner = (state_q == ST_GNT2) ? M2 : M1;

  split_tracker #(
    .SPLIT_TMO_W (SPLIT_TMO_W)
  ) u_split_tracker (
    .clk        (clk),
    .rst        (rst),
    .take       (split_take),
    .take_owner (take_owner),
    .split_done (split_done),
    .arb_idle   (state_q == ST_IDLE),
    .rec_valid  (rec_valid),
    .rec_owner  (rec_owner),
    .resume     (resume),
    .msplit1    (ms1),
    .msplit2    (ms2),
    .split_tmo  (split_tmo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      msel_q  <= M1;
      arm_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= M1;
`endif
    end else begin
      state_q <= state_d;
      msel_q  <= msel_d;
      arm_q   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next-state logic; a resume from a split outranks any fresh request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (resume) begin
          state_d = (rec_owner == M2) ? ST_GNT2 : ST_GNT1;
        end else if (arm_q) begin
          if (req1_eff && req2_eff) begin
            state_d = (tie_pick == M2) ? ST_GNT2 : ST_GNT1;
          end else if (req1_eff) begin
            state_d = ST_GNT1;
          end else if (req2_eff) begin
            state_d = ST_GNT2;
          end
        end
      end
      ST_GNT1: if (!breq1 || split_take) state_d = ST_IDLE;
      ST_GNT2: if (!breq2 || split_take) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    grant_start = (state_q == ST_IDLE) && (state_d != ST_IDLE);
    grant_id    = (state_d == ST_GNT2) ? M2 : M1;
    msel_d      = grant_start ? grant_id : msel_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = grant_start ? grant_id : last_q;
`endif
  end

  // Outputs
  always_comb begin
    bgrant1   = (state_q == ST_GNT1);
    bgrant2   = (state_q == ST_GNT2);
    msel      = msel_q;
    msplit1   = ms1;
    msplit2   = ms2;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Self-checking bench for split_bus_arbiter (SPLIT_TMO_W = 4). Directed
// scenarios plus randomized traffic, all compared against a cycle-level
// behavioural model of the arbitration and split rules.
module tb_split_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int TMO_W     = 4;
  localparam int TMO_LIMIT = (1 << TMO_W) - 1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [1:0] EXP_TIE1 = 2'b01;
`else
  localparam logic [1:0] EXP_TIE1 = 2'b10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic breq1 = 1'b0, breq2 = 1'b0, split = 1'b0, split_done = 1'b0;
  logic bgrant1, bgrant2, msel, msplit1, msplit2, split_tmo;
  arb_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  split_bus_arbiter #(.SPLIT_TMO_W(TMO_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .breq1      (breq1),
    .breq2      (breq2),
    .split      (split),
    .split_done (split_done),
    .bgrant1    (bgrant1),
    .bgrant2    (bgrant2),
    .msel       (msel),
    .msplit1    (msplit1),
    .msplit2    (msplit2),
    .split_tmo  (split_tmo),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; breq1 = 1'b0; breq2 = 1'b0; split = 1'b0; split_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model: who owns the bus (0 none, 1 M1, 2 M2), the parked
  // master and its age, and whether its resume is already known.
  int m_own = 0, m_msel = 0, m_sv = 0, m_sw = 0, m_age = 0;
  int m_dl = 0, m_tmo = 0, m_arm = 0, m_rr = 1;

  always @(posedge clk) begin
    int  new_own;
    bit  pend, r1, r2, take, res;
    if (rst) begin
      m_own = 0; m_msel = 0; m_sv = 0; m_sw = 0; m_age = 0;
      m_dl = 0; m_tmo = 0; m_arm = 0; m_rr = 1;
    end else begin
      pend = m_sv != 0 && (split_done || m_dl != 0);
      r1   = breq1 && !(m_sv != 0 && m_sw == 1);
      r2   = breq2 && !(m_sv != 0 && m_sw == 2);
      take = m_own != 0 && split && m_sv == 0;
      res  = pend && m_own == 0;
      new_own = m_own;
      m_tmo = 0;
      if (m_own == 0) begin
        if (res) new_own = m_sw;
        else if (m_arm != 0) begin
          if (r1 && r2) begin
`ifdef ARB_ROUND_ROBIN_EN
            new_own = (m_rr == 1) ? 2 : 1;
`else
            new_own = 1;
`endif
          end else if (r1) new_own = 1;
          else if (r2) new_own = 2;
        end
      end else if (take || (m_own == 1 && !breq1) || (m_own == 2 && !breq2)) begin
        new_own = 0;
      end
      if (take) begin
        m_sv = 1; m_sw = m_own; m_age = 0; m_dl = 0;
      end else if (m_sv != 0) begin
        if (res) begin m_sv = 0; m_dl = 0; end
        else if (pend) m_dl = 1;
        else if (m_age + 1 == TMO_LIMIT) begin m_sv = 0; m_tmo = 1; end
        else m_age = m_age + 1;
      end
      if (m_own == 0 && new_own != 0) begin
        m_msel = (new_own == 2) ? 1 : 0;
        m_rr   = new_own;
      end
      m_own = new_own;
      m_arm = 1;
    end
    exp_q.push_back({m_own == 1, m_own == 2, m_msel == 1,
                     m_sv != 0 && m_sw == 1, m_sv != 0 && m_sw == 2, m_tmo == 1});
  end

  // Scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_outputs", {26'd0, bgrant1, bgrant2, msel, msplit1, msplit2, split_tmo}, {26'd0, e});
    end
  end

  initial begin
    // Reset state and basic grant/release
    do_reset();
    check("reset_outputs", {bgrant1, bgrant2, msel, msplit1, msplit2, split_tmo}, 6'b0);
    tick();
    breq1 = 1'b1;
    tick();
    check("m1_grant", bgrant1, 1'b1);
    check("m1_msel", msel, 1'b0);
    repeat (3) tick();
    breq1 = 1'b0;
    tick();
    check("m1_release", bgrant1, 1'b0);
    tick();

    // Tie-break right after reset, and no grant on the first edge
    do_reset();
    breq1 = 1'b1; breq2 = 1'b1;
    tick();
    check("no_grant_first_edge", {bgrant1, bgrant2}, 2'b00);
    tick();
    check("tie1_winner", {bgrant1, bgrant2}, EXP_TIE1);
    breq1 = 1'b0; breq2 = 1'b0;
    tick();
    breq1 = 1'b1; breq2 = 1'b1;
    tick();
    check("tie2_winner", {bgrant1, bgrant2}, 2'b10);
    breq1 = 1'b0; breq2 = 1'b0;
    tick();
    tick();

    // Split of M1, M2 takes the bus, late split_done resumes M1
    breq1 = 1'b1;
    tick();
    split = 1'b1;
    tick();
    split = 1'b0;
    check("split_drop_grant", {bgrant1, msplit1}, 2'b01);
    breq2 = 1'b1;
    tick();
    check("m2_after_split", {bgrant1, bgrant2}, 2'b01);
    split_done = 1'b1;
    tick();
    split_done = 1'b0;
    check("done_while_m2", {bgrant2, msplit1}, 2'b11);
    breq2 = 1'b0;
    tick();
    check("m2_release_idle", {bgrant1, bgrant2}, 2'b00);
    breq2 = 1'b1;
    tick();
    check("resume_m1", {bgrant1, bgrant2, msplit1}, 3'b100);
    breq1 = 1'b0; breq2 = 1'b0;
    tick();
    tick();

    // Split timeout
    breq1 = 1'b1;
    tick();
    split = 1'b1;
    tick();
    split = 1'b0; breq1 = 1'b0;
    for (int k = 1; k < TMO_LIMIT; k++) begin
      tick();
      check("tmo_early", split_tmo, 1'b0);
    end
    tick();
    check("tmo_pulse", {split_tmo, msplit1}, 2'b10);
    tick();
    check("tmo_one_cycle", split_tmo, 1'b0);

    // split_done in the same cycle as expiry
    breq1 = 1'b1;
    tick();
    split = 1'b1;
    tick();
    split = 1'b0; breq1 = 1'b0;
    repeat (TMO_LIMIT - 1) tick();
    split_done = 1'b1;
    tick();
    split_done = 1'b0;
    check("done_beats_tmo", {bgrant1, msplit1, split_tmo}, 3'b100);
    tick();
    check("done_beats_tmo_after", split_tmo, 1'b0);
    tick();

    // Reset while M1 parked and M2 granted
    breq1 = 1'b1;
    tick();
    split = 1'b1;
    tick();
    split = 1'b0; breq1 = 1'b0; breq2 = 1'b1;
    tick();
    check("pre_reset_state", {bgrant2, msplit1}, 2'b11);
    rst = 1'b1; breq2 = 1'b0;
    tick();
    check("reset_abandon", {bgrant1, bgrant2, msel, msplit1, msplit2, split_tmo}, 6'b0);
    rst = 1'b0;
    tick();
    split_done = 1'b1;
    tick();
    split_done = 1'b0;
    tick();
    check("done_after_reset", {bgrant1, msplit1, split_tmo}, 3'b000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) breq1 = ~breq1;
      if ($urandom_range(0, 3) == 0) breq2 = ~breq2;
      split      = ($urandom_range(0, 7) == 0);
      split_done = ($urandom_range(0, 23) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; split = 1'b0; split_done = 1'b0; breq1 = 1'b0; breq2 = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
